// File: rtl/fractal_sync_rsp_tx.sv
// Downstream response transmitter of a fractal sync node.
// Responses coming down the tree are buffered in a small FIFO. Each buffered
// response is forked onto the left/south port, the right/north port, or both,
// as selected by its sync-direction field (2'b10 LS, 2'b01 RN, 2'b11 both).
// An entry whose direction is 2'b00 is discarded and flagged on drop_o.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   rsp_*_i / rsp_ready_o    incoming response (valid/ready)
//   ls_*                     left/south child response (valid/ready)
//   rn_*                     right/north child response (valid/ready)
//   drop_o                   one-cycle pulse when an sd=2'b00 entry is discarded
//   empty_o, full_o          buffer status
module fractal_sync_rsp_tx #(
  parameter int unsigned LVL_WIDTH  = 2,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [LVL_WIDTH-1:0] rsp_level_i,
  input  logic [ID_WIDTH-1:0]  rsp_id_i,
  input  logic [1:0]           rsp_sd_i,
  input  logic                 rsp_error_i,
  output logic                 ls_valid_o,
  input  logic                 ls_ready_i,
  output logic [LVL_WIDTH-1:0] ls_level_o,
  output logic [ID_WIDTH-1:0]  ls_id_o,
  output logic                 ls_error_o,
  output logic                 rn_valid_o,
  input  logic                 rn_ready_i,
  output logic [LVL_WIDTH-1:0] rn_level_o,
  output logic [ID_WIDTH-1:0]  rn_id_o,
  output logic                 rn_error_o,
  output logic                 drop_o,
  output logic                 empty_o,
  output logic                 full_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W = LVL_WIDTH + ID_WIDTH + 3;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Entry layout: {level, id, sd, error}
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Pending fork mask [ls, rn]; loaded_q says the mask belongs to the head.
  logic [1:0]       mask_q, mask_d;
  logic             loaded_q, loaded_d;

  logic [ENT_W-1:0]     head;
  logic [LVL_WIDTH-1:0] head_level;
  logic [ID_WIDTH-1:0]  head_id;
  logic [1:0]           head_sd;
  logic                 head_error;
  logic                 push, pop;
  logic [1:0]           hs;

  assign head       = mem_q[rd_ptr_q];
  assign head_error = head[0];
  assign head_sd    = head[2:1];
  assign head_id    = head[3 +: ID_WIDTH];
  assign head_level = head[3 + ID_WIDTH +: LVL_WIDTH];

  assign full_o      = (cnt_q == CNT_FULL);
  assign empty_o     = (cnt_q == '0);
  assign rsp_ready_o = !full_o;
  assign ls_valid_o  = mask_q[1];
  assign rn_valid_o  = mask_q[0];
  // A loaded head with an empty mask can only come from sd=2'b00.
  assign drop_o      = loaded_q && (mask_q == 2'b00);

  // Data is gated by valid so idle ports read as zero.
  assign ls_level_o = mask_q[1] ? head_level : '0;
  assign ls_id_o    = mask_q[1] ? head_id    : '0;
  assign ls_error_o = mask_q[1] & head_error;
  assign rn_level_o = mask_q[0] ? head_level : '0;
  assign rn_id_o    = mask_q[0] ? head_id    : '0;
  assign rn_error_o = mask_q[0] & head_error;

  always_comb begin
    push     = rsp_valid_i && !full_o;
    hs       = {mask_q[1] & ls_ready_i, mask_q[0] & rn_ready_i};
    pop      = loaded_q && ((mask_q & ~hs) == 2'b00);
    mask_d   = mask_q & ~hs;
    loaded_d = loaded_q;
    if (pop) begin
      // Leave one idle cycle before the next head is forked.
      loaded_d = 1'b0;
      mask_d   = 2'b00;
    end else if (!loaded_q) begin
      if (!empty_o) begin
        loaded_d = 1'b1;
        mask_d   = head_sd;
      end else if (push) begin
        // Head becomes valid on this write: take its sd straight from the input
        // so the response is visible the cycle after the push.
        loaded_d = 1'b1;
        mask_d   = rsp_sd_i;
      end
    end

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mask_q   <= 2'b00;
      loaded_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      loaded_q <= loaded_d;
    end
  end

  // Storage needs no reset: nothing is read unless the count says it was written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {rsp_level_i, rsp_id_i, rsp_sd_i, rsp_error_i};
  end

endmodule
